video_scan_timing: RTL and testbench
====================================

Name: video_scan_timing

Overview:
- Generates 640x480 scan timing: horizontal/vertical counters, sync pulses, blanking and frame/line strobes.
- Directly upstream of the 8x8 text-area pixel stage. o_scan_row/o_scan_column drive its i_scan_row/i_scan_column.
- Sync and visible outputs can be delayed by a programmable number of pixel ticks. This lets them line up with the colour leaving the downstream blending pipeline at the VGA pins.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_ACTIVE, 0, asserted level of o_hsync/o_vsync (0 = active-low)
PIPE_DELAY, 2, pixel ticks of delay on o_hsync/o_vsync/o_visible_d; range 0..7

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  asynchronous active-low reset
i_pix_en  input  1  pixel tick; counters advance only when high
o_scan_column  output  10  horizontal count 0..H_total-1 (H_total=800)
o_scan_row  output  10  vertical count 0..V_total-1 (V_total=525); downstream uses [8:0] while visible
o_visible  output  1  undelayed: column<H_VISIBLE && row<V_VISIBLE
o_visible_d  output  1  o_visible delayed PIPE_DELAY ticks
o_hsync  output  1  horizontal sync, delayed PIPE_DELAY ticks
o_vsync  output  1  vertical sync, delayed PIPE_DELAY ticks
o_line_start  output  1  one-clock pulse on tick where column wraps to 0
o_frame_start  output  1  one-clock pulse on tick where column and row both wrap to 0
o_frame_count  output  8  frames completed since reset, wraps 255->0

Behaviour:
- Reset (asynchronous, i_rst_n low):
  - column=0, row=0, o_frame_count=0.
  - o_line_start=o_frame_start=0.
  - o_visible=1 (position 0,0 is visible); all delay-line stages cleared to o_visible_d=0 and hsync/vsync deasserted (!SYNC_ACTIVE).
- Reset release is sampled on the clock; the first advance occurs on the first i_pix_en after release.
- On rising i_clk with i_pix_en=1:
  - column increments.
  - At column==H_total-1 the column wraps to 0 and the row increments.
  - At row==V_total-1 with a column wrap, the row wraps to 0 and o_frame_count increments.
- With i_pix_en=0 all counters and delay stages hold. o_line_start/o_frame_start are 0 that cycle (the pulses are exactly one i_clk wide, never stretched).
- All outputs are registered. o_scan_column/o_scan_row/o_visible reflect the same position in the same cycle; there is zero offset between them.
- Horizontal phase is decoded from the registered column:
  - VISIBLE [0,640)
  - FRONT [640,656)
  - SYNC [656,752)
  - BACK [752,800)
- Vertical phase is decoded from the row:
  - VISIBLE [0,480)
  - FRONT [480,490)
  - SYNC [490,492)
  - BACK [492,525)
- Raw hsync = SYNC_ACTIVE during horizontal SYNC, else !SYNC_ACTIVE; vsync likewise per row. vsync changes only on line boundaries (column==0).
- Delay line: a shift register of PIPE_DELAY stages of {visible, hsync, vsync}.
  - Shifts only on i_pix_en.
  - PIPE_DELAY=0 means o_hsync/o_vsync/o_visible_d equal the undelayed decode in the same cycle.
- o_line_start asserts in the clock cycle whose registered column becomes 0, i.e. coincident with column==0 first appearing.
- o_frame_start asserts coincident with row==0 && column==0 first appearing. o_line_start is also high that cycle.
- Widths: counters are sized from H_total/V_total and must not overflow for the default parameters. Comparisons are unsigned.
- Reset mid-frame: counters return to 0 immediately (asynchronously). No partial sync pulse is extended; the sync outputs go inactive at once.

Test Plan:
- Reset then i_pix_en held 1 for 800 clocks -> column runs 0..799, wraps to 0 with o_line_start=1 in that cycle; row=1; o_frame_start=0.
- Run 420000 ticks (one frame) -> o_frame_start=1 exactly once, at the wrap to (0,0); o_frame_count=1; o_vsync low for exactly 1600 ticks (rows 490-491) with PIPE_DELAY=0.
- PIPE_DELAY=2, measure hsync -> first o_hsync low at column 658, high again at column 754; o_visible_d falls at column 642.
- i_pix_en toggling 1,0,1,0 -> column advances every other clock; o_line_start is a single-clock pulse, not two; outputs hold during i_pix_en=0.
- Assert i_rst_n low at row 300, column 500, without a clock edge -> outputs immediately column=0, row=0, hsync/vsync inactive, o_frame_count=0; counting resumes after release.
- Run 256 frames -> o_frame_count wraps 255->0 on the 256th o_frame_start.

Source files
------------

// File: rtl/video_scan_timing.sv
// 640x480 scan timing generator: column/row counters, sync and blanking decode,
// line/frame strobes and a PIPE_DELAY-stage delay line aligning sync with pixel colour.
module video_scan_timing #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter bit SYNC_ACTIVE = 1'b0,
    parameter int PIPE_DELAY  = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_pix_en,
    output logic [9:0] o_scan_column,
    output logic [9:0] o_scan_row,
    output logic       o_visible,
    output logic       o_visible_d,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_line_start,
    output logic       o_frame_start,
    output logic [7:0] o_frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
    localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
    localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("video_scan_timing: line or frame total does not fit the 10-bit counters");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_delay
        $error("video_scan_timing: PIPE_DELAY must be within 0..7");
    end

    typedef struct packed {
        logic visible;
        logic hsync;
        logic vsync;
    } scan_flags_t;

    // Position (0,0) is visible with both syncs idle; empty delay stages show blanking.
    localparam scan_flags_t FLAGS_HOME  = '{visible: 1'b1, hsync: ~SYNC_ACTIVE, vsync: ~SYNC_ACTIVE};
    localparam scan_flags_t FLAGS_CLEAR = '{visible: 1'b0, hsync: ~SYNC_ACTIVE, vsync: ~SYNC_ACTIVE};

    logic [9:0]  column_q, column_d;
    logic [9:0]  row_q, row_d;
    logic [7:0]  frame_count_q, frame_count_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;
    scan_flags_t flags_q, flags_d;
    scan_flags_t flags_delayed;

    // Flags are decoded from the next position so they register alongside the counters.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        column_d      = column_q;
        row_d         = row_q;
        frame_count_d = frame_count_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;

        if (i_pix_en) begin
            if (column_q == H_LAST) begin
                column_d     = '0;
                line_start_d = 1'b1;
                if (row_q == V_LAST) begin
                    row_d         = '0;
                    frame_start_d = 1'b1;
                    frame_count_d = frame_count_q + 8'd1;
                end else begin
                    row_d = row_q + 10'd1;
                end
            end else begin
                column_d = column_q + 10'd1;
            end
        end

        flags_d.visible = (column_d < H_VIS_END) && (row_d < V_VIS_END);
        flags_d.hsync   = (column_d >= HS_START && column_d < HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        flags_d.vsync   = (row_d >= VS_START && row_d < VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            column_q      <= '0;
            row_q         <= '0;
            frame_count_q <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            flags_q       <= FLAGS_HOME;
        end else begin
            column_q      <= column_d;
            row_q         <= row_d;
            frame_count_q <= frame_count_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            flags_q       <= flags_d;
        end
    end

    if (PIPE_DELAY == 0) begin : g_no_delay
        assign flags_delayed = flags_q;
    end else begin : g_delay
        scan_flags_t pipe_q [PIPE_DELAY];

        // NOTE: the delay stages are reset so no stale sync pulse leaks out after a mid-frame reset.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                for (int i = 0; i < PIPE_DELAY; i++) begin
                    pipe_q[i] <= FLAGS_CLEAR;
                end
            end else if (i_pix_en) begin
                pipe_q[0] <= flags_q;
                for (int i = 1; i < PIPE_DELAY; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign flags_delayed = pipe_q[PIPE_DELAY-1];
    end

    assign o_scan_column = column_q;
    assign o_scan_row    = row_q;
    assign o_visible     = flags_q.visible;
    assign o_visible_d   = flags_delayed.visible;
    assign o_hsync       = flags_delayed.hsync;
    assign o_vsync       = flags_delayed.vsync;
    assign o_line_start  = line_start_q;
    assign o_frame_start = frame_start_q;
    assign o_frame_count = frame_count_q;

endmodule

// File: tb/tb_video_scan_timing.sv
// Bench for video_scan_timing: a default-timing instance (PIPE_DELAY=2) and a tiny-timing
// instance (15x8 totals, PIPE_DELAY=0) so whole frames and the frame-count wrap fit the run.
module tb_video_scan_timing;

    logic clk    = 1'b0;
    logic rst_n  = 1'b1;
    logic pix_en = 1'b0;

    always #5 clk = ~clk;

    logic [9:0] d2_col, d2_row, ds_col, ds_row;
    logic       d2_vis, d2_vd, d2_hs, d2_vs, d2_ls, d2_fs;
    logic       ds_vis, ds_vd, ds_hs, ds_vs, ds_ls, ds_fs;
    logic [7:0] d2_fc, ds_fc;

    video_scan_timing dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en),
        .o_scan_column(d2_col), .o_scan_row(d2_row),
        .o_visible(d2_vis), .o_visible_d(d2_vd),
        .o_hsync(d2_hs), .o_vsync(d2_vs),
        .o_line_start(d2_ls), .o_frame_start(d2_fs),
        .o_frame_count(d2_fc)
    );

    video_scan_timing #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .SYNC_ACTIVE(1'b0), .PIPE_DELAY(0)
    ) dut_s (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en),
        .o_scan_column(ds_col), .o_scan_row(ds_row),
        .o_visible(ds_vis), .o_visible_d(ds_vd),
        .o_hsync(ds_hs), .o_vsync(ds_vs),
        .o_line_start(ds_ls), .o_frame_start(ds_fs),
        .o_frame_count(ds_fc)
    );

    int total = 0;
    int bad   = 0;
    int line_q[$];
    int frame_q[$];
    int unexpected_lines  = 0;
    int unexpected_frames = 0;
    int d2_frame_starts   = 0;
    int exp_row, exp_fc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: line strobes of dut2 and frame strobes of dut_s pop expectations.
    always @(negedge clk) begin
        if (d2_ls === 1'b1) begin
            if (line_q.size() == 0) begin
                unexpected_lines++;
            end else begin
                exp_row = line_q.pop_front();
                check("line_row", d2_row, exp_row);
                check("line_col", d2_col, 0);
            end
        end
        if (d2_fs === 1'b1) d2_frame_starts++;
        if (ds_fs === 1'b1) begin
            if (frame_q.size() == 0) begin
                unexpected_frames++;
            end else begin
                exp_fc = frame_q.pop_front();
                check("frame_count", ds_fc, exp_fc);
                check("frame_pos", {ds_row, ds_col}, 0);
                check("frame_line_start", ds_ls, 1);
            end
        end
    end

    int first_hlow   = -1;
    int first_hhigh  = -1;
    int first_vdfall = -1;
    int vs_low       = 0;
    int fs_cnt       = 0;
    int toggle_err   = 0;
    int ls_cnt       = 0;
    int prev_col;
    logic prev_vd;

    initial begin
        // Asynchronous reset with no clock edge involved.
        #1 rst_n = 1'b0;
        #1;
        check("rst_col", d2_col, 0);
        check("rst_row", d2_row, 0);
        check("rst_fc", d2_fc, 0);
        check("rst_visible", d2_vis, 1);
        check("rst_visible_d", d2_vd, 0);
        check("rst_hsync", d2_hs, 1);
        check("rst_vsync", d2_vs, 1);
        check("rst_strobes", {d2_ls, d2_fs}, 0);
        check("rst_s_visible_d", ds_vd, 1);

        // First line: column sweep, delayed hsync/visible edges, one small frame's vsync.
        line_q.push_back(1);
        for (int f = 1; f <= 6; f++) frame_q.push_back(f);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        pix_en = 1'b1;
        prev_vd = d2_vd;
        for (int k = 1; k <= 800; k++) begin
            @(posedge clk); #1;
            if (first_hlow < 0 && d2_hs == 1'b0) first_hlow = int'(d2_col);
            else if (first_hlow >= 0 && first_hhigh < 0 && d2_hs == 1'b1) first_hhigh = int'(d2_col);
            if (first_vdfall < 0 && prev_vd && !d2_vd) first_vdfall = int'(d2_col);
            prev_vd = d2_vd;
            if (k <= 120) begin
                if (!ds_vs) vs_low++;
                if (ds_fs) fs_cnt++;
            end
            if (k == 799) begin
                check("col_799", d2_col, 799);
                check("ls_before_wrap", d2_ls, 0);
            end
            if (k == 800) begin
                check("wrap_col", d2_col, 0);
                check("wrap_row", d2_row, 1);
                check("wrap_ls", d2_ls, 1);
                check("wrap_fs", d2_fs, 0);
            end
        end
        check("hsync_fall_col", first_hlow, 658);
        check("hsync_rise_col", first_hhigh, 754);
        check("visible_d_fall_col", first_vdfall, 642);
        check("s_vsync_low_ticks", vs_low, 30);
        check("s_frame_starts_one_frame", fs_cnt, 1);

        // pix_en toggling: advance on enabled clocks only, single-clock line strobe.
        line_q.push_back(2);
        for (int f = 7; f <= 13; f++) frame_q.push_back(f);
        for (int i = 0; i < 1600; i++) begin
            pix_en   = (i % 2 == 0);
            prev_col = int'(d2_col);
            @(posedge clk); #1;
            if (pix_en) begin
                if (int'(d2_col) != ((prev_col == 799) ? 0 : prev_col + 1)) toggle_err++;
            end else begin
                if (int'(d2_col) != prev_col || d2_ls) toggle_err++;
            end
            if (d2_ls) ls_cnt++;
        end
        check("toggle_errors", toggle_err, 0);
        check("toggle_line_pulses", ls_cnt, 1);
        check("toggle_row", d2_row, 2);

        // Run into hsync (dut2) and vsync (dut_s), then reset between clock edges.
        for (int f = 14; f <= 18; f++) frame_q.push_back(f);
        pix_en = 1'b1;
        run(660);
        check("pre_rst_col", d2_col, 660);
        check("pre_rst_row", d2_row, 2);
        check("pre_rst_hsync", d2_hs, 0);
        check("pre_rst_s_pos", {ds_row, ds_col}, {10'd6, 10'd10});
        check("pre_rst_s_vsync", ds_vs, 0);
        check("pre_rst_s_fc", ds_fc, 18);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_pos", {d2_row, d2_col}, 0);
        check("mid_rst_syncs", {d2_hs, d2_vs}, 2'b11);
        check("mid_rst_visible_d", d2_vd, 0);
        check("mid_rst_s_pos", {ds_row, ds_col}, 0);
        check("mid_rst_s_vsync", ds_vs, 1);
        check("mid_rst_s_fc", ds_fc, 0);
        run(3);
        rst_n = 1'b1;
        run(5);
        check("resume_col", d2_col, 5);
        check("resume_row", d2_row, 0);
        check("resume_s_col", ds_col, 5);

        // 256 small frames: frame count wraps 255 -> 0 on the last strobe.
        rst_n = 1'b0;
        run(2);
        rst_n = 1'b1;
        for (int r = 1; r <= 38; r++) line_q.push_back(r);
        for (int f = 1; f <= 255; f++) frame_q.push_back(f);
        frame_q.push_back(0);
        run(30720);
        @(negedge clk); #1;
        check("final_s_fc", ds_fc, 0);
        check("final_s_pos", {ds_row, ds_col}, 0);
        check("line_q_left", line_q.size(), 0);
        check("frame_q_left", frame_q.size(), 0);
        check("unexpected_lines", unexpected_lines, 0);
        check("unexpected_frames", unexpected_frames, 0);
        check("dut2_frame_starts", d2_frame_starts, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
